// File: rtl/fofb_dma_frame_sched.sv
// Frame scheduler for the BMD TX engine MWr path: one DMA per timeframe into a host ring of slots,
// with watchdog abort, overrun detection and a per-frame write-DMA interrupt.
module fofb_dma_frame_sched #(
    parameter int FRAME_BYTES = 2048,
    parameter int SLOT_W      = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [31:0]       base_addr_i,
    input  logic [SLOT_W-1:0] nslots_i,
    input  logic              timeframe_end_i,
    output logic              mwr_start_o,
    output logic [31:0]       mwr_addr_o,
    input  logic              mwr_done_i,
    output logic              wdma_irq_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic [31:0]       frame_cnt_o,
    output logic              overrun_o,
    output logic              timeout_o,
    input  logic              err_clr_i,
    output logic              busy_o
);
    localparam int FB_SH = $clog2(FRAME_BYTES);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              tf_q;
    logic              en_q;
    logic              tf_rise;
    logic              en_rise;
    logic [31:0]       base_q;
    logic [SLOT_W-1:0] depth_q;
    logic [SLOT_W-1:0] depth_m1;
    logic [SLOT_W-1:0] ptr;
    logic [SLOT_W-1:0] ptr_nxt;
    logic [WD_W-1:0]   wd;
    logic              rearm;
    logic              xfer_ok;
    logic              xfer_abort;

    assign tf_rise  = timeframe_end_i & ~tf_q;
    assign en_rise  = enable_i & ~en_q;
    assign depth_m1 = depth_q - SLOT_W'(1);
    assign ptr_nxt  = (ptr == depth_m1) ? '0 : ptr + SLOT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tf_rise && enable_i) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (mwr_done_i || wd == WD_MAX) state_nxt = RELEASE;
            RELEASE: if (!mwr_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Start is a pure decode of WAIT, so it rises one edge after START and drops on the done/abort edge.
    always_comb begin
        mwr_start_o = (state == WAIT);
        busy_o      = (state != IDLE);
        xfer_ok     = (state == WAIT) && mwr_done_i;
        xfer_abort  = (state == WAIT) && !mwr_done_i && (wd == WD_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tf_q        <= 1'b0;
            en_q        <= 1'b0;
            base_q      <= '0;
            depth_q     <= SLOT_W'(1);
            ptr         <= '0;
            rearm       <= 1'b0;
            wd          <= '0;
            mwr_addr_o  <= '0;
            wdma_irq_o  <= 1'b0;
            slot_idx_o  <= '0;
            frame_cnt_o <= '0;
            overrun_o   <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            tf_q       <= timeframe_end_i;
            en_q       <= enable_i;
            wdma_irq_o <= xfer_ok;
            wd         <= (state == WAIT) ? wd + WD_W'(1) : '0;

            if (en_rise) begin
                base_q  <= base_addr_i;
                depth_q <= (nslots_i == '0) ? SLOT_W'(1) : nslots_i;
            end

            if (xfer_ok) begin
                frame_cnt_o <= frame_cnt_o + 32'd1;
                slot_idx_o  <= ptr;
            end

            // A re-enable while the engine holds start must not move the address under it;
            // the ring restart is deferred until that transfer leaves WAIT.
            if (en_rise && state == WAIT) begin
                rearm <= 1'b1;
            end
            if (en_rise && state != WAIT) begin
                ptr        <= '0;
                mwr_addr_o <= base_addr_i;
                rearm      <= 1'b0;
            end else if ((xfer_ok || xfer_abort) && (rearm || en_rise)) begin
                ptr        <= '0;
                mwr_addr_o <= en_rise ? base_addr_i : base_q;
                rearm      <= 1'b0;
            end else if (xfer_ok) begin
                ptr        <= ptr_nxt;
                mwr_addr_o <= base_q + (32'(ptr_nxt) << FB_SH);
            end

            if (tf_rise && state != IDLE) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end

            if (xfer_abort) begin
                timeout_o <= 1'b1;
            end else if (err_clr_i) begin
                timeout_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fofb_dma_frame_sched.sv
// Bench for fofb_dma_frame_sched: vector table for the ring walk, hand sequences for the
// overrun/timeout/enable/reset corners, then randomized rings against a slot-level model.
module tb_fofb_dma_frame_sched;
    localparam int SLOT_W = 8;
    localparam int FB     = 2048;
    localparam int TO     = 100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [31:0]       base_addr;
    logic [SLOT_W-1:0] nslots;
    logic              tf_end;
    logic              mwr_start;
    logic [31:0]       mwr_addr;
    logic              mwr_done;
    logic              wdma_irq;
    logic [SLOT_W-1:0] slot_idx;
    logic [31:0]       frame_cnt;
    logic              overrun;
    logic              timeout;
    logic              err_clr;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    fofb_dma_frame_sched #(
        .FRAME_BYTES(FB),
        .SLOT_W     (SLOT_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .base_addr_i    (base_addr),
        .nslots_i       (nslots),
        .timeframe_end_i(tf_end),
        .mwr_start_o    (mwr_start),
        .mwr_addr_o     (mwr_addr),
        .mwr_done_i     (mwr_done),
        .wdma_irq_o     (wdma_irq),
        .slot_idx_o     (slot_idx),
        .frame_cnt_o    (frame_cnt),
        .overrun_o      (overrun),
        .timeout_o      (timeout),
        .err_clr_i      (err_clr),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_delay;
        logic [31:0] exp_addr;
        int          exp_slot;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(mwr_start), 32'd0);
        check({tag, "_addr"},  mwr_addr,       32'd0);
        check({tag, "_irq"},   32'(wdma_irq),  32'd0);
        check({tag, "_slot"},  32'(slot_idx),  32'd0);
        check({tag, "_cnt"},   frame_cnt,      32'd0);
        check({tag, "_ovr"},   32'(overrun),   32'd0);
        check({tag, "_tmo"},   32'(timeout),   32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // One complete frame: tf rise, start two cycles on, done after done_delay cycles of start.
    task automatic run_frame(input int done_delay, input logic [31:0] exp_addr,
                             input int exp_slot, input logic [31:0] exp_cnt);
        tf_end = 1'b1;
        tick();
        check("start_not_yet", 32'(mwr_start), 32'd0);
        check("busy_in_start", 32'(busy), 32'd1);
        tf_end = 1'b0;
        tick();
        check("start_at_n2", 32'(mwr_start), 32'd1);
        check("addr", mwr_addr, exp_addr);
        for (int i = 0; i < done_delay - 1; i++) begin
            tick();
            check("start_hold", 32'(mwr_start), 32'd1);
            check("addr_stable", mwr_addr, exp_addr);
        end
        mwr_done = 1'b1;
        tick();
        check("start_drop", 32'(mwr_start), 32'd0);
        check("irq_pulse", 32'(wdma_irq), 32'd1);
        check("frame_cnt", frame_cnt, exp_cnt);
        check("slot_idx", 32'(slot_idx), 32'(exp_slot));
        mwr_done = 1'b0;
        tick();
        check("irq_one_cycle", 32'(wdma_irq), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    // One aborted frame: start must stay up exactly TO+1 cycles, no irq, count unchanged.
    task automatic run_timeout(input logic [31:0] exp_addr, input logic [31:0] exp_cnt);
        int  n;
        logic irq_seen;
        irq_seen = 1'b0;
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        check("tmo_start", 32'(mwr_start), 32'd1);
        check("tmo_addr", mwr_addr, exp_addr);
        n = 1;
        for (int i = 0; i < 3 * TO; i++) begin
            tick();
            if (wdma_irq) irq_seen = 1'b1;
            if (!mwr_start) break;
            n++;
        end
        check("tmo_start_cycles", 32'(n), 32'(TO + 1));
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_no_irq", 32'(irq_seen), 32'd0);
        check("tmo_cnt", frame_cnt, exp_cnt);
        tick();
        check("tmo_idle", 32'(busy), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_clr", 32'(timeout), 32'd0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] m_base;
        logic [31:0] m_cnt;
        int          m_depth;
        int          m_ptr;
        int          nfr;

        vecs[0] = '{20, 32'h1000_0000, 0, 32'd1};
        vecs[1] = '{20, 32'h1000_0800, 1, 32'd2};
        vecs[2] = '{20, 32'h1000_1000, 2, 32'd3};
        vecs[3] = '{20, 32'h1000_1800, 3, 32'd4};
        vecs[4] = '{20, 32'h1000_0000, 0, 32'd5};

        rst_n     = 1'b0;
        enable    = 1'b0;
        base_addr = 32'h1000_0000;
        nslots    = 8'd4;
        tf_end    = 1'b0;
        mwr_done  = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Ring walk over four slots with wrap.
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check("addr_after_enable", mwr_addr, 32'h1000_0000);
        foreach (vecs[i]) begin
            run_frame(vecs[i].done_delay, vecs[i].exp_addr, vecs[i].exp_slot, vecs[i].exp_cnt);
        end
        check("addr_after_wrap", mwr_addr, 32'h1000_0800);

        // Overrun: second tf rise ten cycles after the first, while in WAIT.
        do_reset();
        enable = 1'b1;
        tick();
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        repeat (8) tick();
        tf_end = 1'b1;
        tick();
        check("overrun_set", 32'(overrun), 32'd1);
        tf_end = 1'b0;
        tick();
        check("ovr_still_one_xfer", 32'(mwr_start), 32'd1);
        mwr_done = 1'b1;
        tick();
        check("ovr_irq", 32'(wdma_irq), 32'd1);
        mwr_done = 1'b0;
        repeat (6) tick();
        check("ovr_no_second_start", 32'(mwr_start), 32'd0);
        check("ovr_frame_cnt", frame_cnt, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'd0);

        // Set beats clear when both land on the same edge.
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        tf_end  = 1'b1;
        err_clr = 1'b1;
        tick();
        check("ovr_set_wins", 32'(overrun), 32'd1);
        tf_end   = 1'b0;
        err_clr  = 1'b0;
        mwr_done = 1'b1;
        tick();
        mwr_done = 1'b0;
        tick();
        check("ovr_cnt2", frame_cnt, 32'd2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("overrun_clr2", 32'(overrun), 32'd0);

        // Watchdog abort, then the same slot is reused.
        run_timeout(32'h1000_1000, 32'd2);
        run_frame(5, 32'h1000_1000, 2, 32'd3);

        // Enable dropped mid-transfer: frame completes, next edge ignored.
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        mwr_done = 1'b1;
        tick();
        check("dis_irq", 32'(wdma_irq), 32'd1);
        check("dis_cnt", frame_cnt, 32'd4);
        mwr_done = 1'b0;
        tick();
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        tick();
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_no_start", 32'(mwr_start), 32'd0);
        check("dis_cnt_hold", frame_cnt, 32'd4);
        check("dis_no_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of WAIT.
        enable = 1'b1;
        tick();
        tf_end = 1'b1;
        tick();
        tf_end = 1'b0;
        tick();
        tick();
        check("rst_mid_start", 32'(mwr_start), 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;

        // Randomized rings against the slot-level model.
        m_cnt = 32'd0;
        for (int r = 0; r < 6; r++) begin
            enable = 1'b0;
            tick();
            nslots    = 8'($urandom_range(0, 6));
            base_addr = (r == 5) ? 32'hFFFF_F000 : ($urandom & 32'hFFFF_F800);
            enable    = 1'b1;
            tick();
            m_base  = base_addr;
            m_depth = (nslots == 0) ? 1 : int'(nslots);
            m_ptr   = 0;
            check("rnd_addr_enable", mwr_addr, m_base);
            nfr = $urandom_range(3, 9);
            for (int f = 0; f < nfr; f++) begin
                if ($urandom_range(0, 9) == 0) begin
                    run_timeout(m_base + 32'(m_ptr * FB), m_cnt);
                end else begin
                    run_frame($urandom_range(1, 25), m_base + 32'(m_ptr * FB), m_ptr, m_cnt + 32'd1);
                    m_cnt = m_cnt + 32'd1;
                    m_ptr = (m_ptr + 1) % m_depth;
                    check("rnd_next_addr", mwr_addr, m_base + 32'(m_ptr * FB));
                end
                repeat ($urandom_range(0, 3)) tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
